com_regbridge: RTL and testbench

- Parametrised successor to the 4-channel UART register bridge.
- Host writes NCHAN registers of DW bits over ASCII-hex UART commands, and reads them back on demand.
- FPGA-side inputs are change-reported automatically with round-robin fairness.
- Sits between the board UART pins and user logic; reuses the existing uart_rx/uart_tx cores unchanged.

---
 rtl/com_pkg.sv | 26 ++
 rtl/com_tx_framer.sv | 67 ++++++
 rtl/uart_rx.sv | 43 ++++
 rtl/uart_tx.sv | 39 +++
 rtl/com_regbridge.sv | 167 ++++++++++++++++
 tb/tb_com_regbridge.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/com_pkg.sv
// com_pkg: shared ASCII constants, state encodings and hex helpers for com_regbridge
package com_pkg;

    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_D  = 8'h44;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {RX_IDLE, RX_WCH, RX_WDAT, RX_RCH} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic {FR_DATA, FR_ACK} frame_t;

    // {valid, nibble}; accepts 0-9, A-F, a-f
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ? {1'b1, c[3:0]} :
               ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) ? {1'b1, c[3:0] + 4'd9} :
               5'd0;
    endfunction

    // uppercase hex character for a nibble
    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        return n < 4'd10 ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/com_tx_framer.sv
// com_tx_framer: serialises one D or K frame into characters and drives the uart_tx handshake
module com_tx_framer
    import com_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          valid,
    output logic          ready,
    input  frame_t        ftype,
    input  logic [3:0]    chan,
    input  logic [DW-1:0] value,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data
);
    localparam int ND = DW / 4;
    localparam logic [3:0] DAT_LAST = 4'(ND + 2);

    tx_state_t     st;
    frame_t        ty;
    logic [3:0]    ch, idx;
    logic [DW-1:0] sr;
    logic [7:0]    cur;
    logic          last;

    assign ready = st == TX_IDLE;

    // character at the current position: lead letter, channel digit, value digits, LF
    always_comb begin
        cur  = idx == 4'd0 ? (ty == FR_ACK ? CH_K : CH_D) :
               idx == 4'd1 ? nib2hex(ch) :
               (ty == FR_DATA && idx < DAT_LAST) ? nib2hex(sr[DW-1 -: 4]) : CH_LF;
        last = idx == (ty == FR_ACK ? 4'd2 : DAT_LAST);
    end

    // one character per start/busy handshake; value digits shift out MSB-first
    always_ff @(posedge CLK) begin
        if (RST) begin
            st       <= TX_IDLE;
            ty       <= FR_DATA;
            ch       <= 4'd0;
            idx      <= 4'd0;
            sr       <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'd0;
        end else if (st == TX_IDLE) begin
            if (valid) begin
                st  <= TX_SEND;
                ty  <= ftype;
                ch  <= chan;
                sr  <= value;
                idx <= 4'd0;
            end
        end else if (!tx_busy && !tx_start) begin
            tx_start <= 1'b1;
            tx_data  <= cur;
        end else if (tx_busy && tx_start) begin
            tx_start <= 1'b0;
            idx      <= idx + 4'd1;
            if (idx >= 4'd2) sr <= sr << 4;
            if (last) st <= TX_IDLE;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, one-cycle rx_ready with rx_data; not reset, idles on a high line
module uart_rx #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       CLK,
    input  logic       RX,
    output logic       rx_ready,
    output logic [7:0] rx_data
);
    localparam int DIV = CLK_FREQ / BAUD;

    logic [1:0]  syn_n;
    logic        rxb, act;
    logic [15:0] cnt;
    logic [3:0]  bits;

    assign rxb = ~syn_n[1];

    // synchronise the line (stored inverted so power-up reads idle), then sample each bit mid-period
    always_ff @(posedge CLK) begin
        syn_n    <= {syn_n[0], ~RX};
        rx_ready <= 1'b0;
        if (!act) begin
            if (!rxb) begin
                act  <= 1'b1;
                cnt  <= 16'(DIV / 2);
                bits <= 4'd0;
            end
        end else if (cnt != 16'(DIV - 1)) begin
            cnt <= cnt + 16'd1;
        end else begin
            cnt  <= 16'd0;
            bits <= bits + 4'd1;
            if (bits == 4'd0 && rxb) act <= 1'b0;
            else if (bits == 4'd9) begin
                act      <= 1'b0;
                rx_ready <= rxb;
            end else if (bits != 4'd0) rx_data <= {rxb, rx_data[7:1]};
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter, accepts tx_start while idle and holds tx_busy until the stop bit ends
module uart_tx #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       CLK,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_busy
);
    localparam int DIV = CLK_FREQ / BAUD;

    logic [9:0]  sh;
    logic [15:0] cnt;
    logic [3:0]  bits;

    assign TX = tx_busy ? sh[0] : 1'b1;

    // load start/data/stop on an idle start request, then shift one bit per baud period
    always_ff @(posedge CLK) begin
        if (!tx_busy) begin
            if (tx_start) begin
                tx_busy <= 1'b1;
                sh      <= {1'b1, tx_data, 1'b0};
                cnt     <= 16'd0;
                bits    <= 4'd0;
            end
        end else if (cnt != 16'(DIV - 1)) begin
            cnt <= cnt + 16'd1;
        end else begin
            cnt  <= 16'd0;
            sh   <= {1'b1, sh[9:1]};
            bits <= bits + 4'd1;
            if (bits == 4'd9) tx_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/com_regbridge.sv
// com_regbridge: ASCII-hex UART bridge; host writes/reads NCHAN registers of DW bits, DATA_OUT changes auto-reported
// Optional: define COMREGBRIDGE_ACK_EN to answer each accepted write with "K<ch>\n"
module com_regbridge
    import com_pkg::*;
#(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115200,
    parameter int NCHAN    = 4,
    parameter int DW       = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RX,
    output logic                TX,
    output logic [NCHAN*DW-1:0] DATA_IN,
    output logic [NCHAN-1:0]    WR_STB,
    input  logic [NCHAN*DW-1:0] DATA_OUT
);
    localparam int ND = DW / 4;
    localparam logic [3:0] WLAST = 4'(ND - 1);

    logic          rx_ready, tx_start, tx_busy, fr_ready, accept;
    logic [7:0]    rx_data, tx_data;
    rx_state_t     rx_st;
    logic [3:0]    wch, cnt, rr, hn;
    logic          hv, wr_fire, rd_fire;
    logic [DW-1:0] acc, acc_n;
    logic [NCHAN-1:0] rd_pend, chg;
    logic [DW-1:0] shadow [NCHAN];
    logic          hi_v, lo_v, sel_v;
    logic [3:0]    hi_k, lo_k, sel_k;
    frame_t        sel_t;
    logic [DW-1:0] sel_val;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .CLK(CLK), .RX(RX), .rx_ready(rx_ready), .rx_data(rx_data)
    );

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
        .CLK(CLK), .tx_start(tx_start), .tx_data(tx_data), .TX(TX), .tx_busy(tx_busy)
    );

    com_tx_framer #(.DW(DW)) u_framer (
        .CLK(CLK), .RST(RST), .valid(sel_v), .ready(fr_ready), .ftype(sel_t), .chan(sel_k),
        .value(sel_val), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data)
    );

    assign {hv, hn} = hex2nib(rx_data);
    assign acc_n    = (acc << 4) | DW'(hn);
    assign wr_fire  = rx_ready && rx_st == RX_WDAT && hv && cnt == WLAST;
    assign rd_fire  = rx_ready && rx_st == RX_RCH && hv;
    assign accept   = sel_v && fr_ready;

    // command parser, advanced only on received characters; S/R always restart a command
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_st <= RX_IDLE;
            wch   <= 4'd0;
            cnt   <= 4'd0;
            acc   <= '0;
        end else if (rx_ready) begin
            if (rx_data == CH_S) rx_st <= RX_WCH;
            else if (rx_data == CH_R) rx_st <= RX_RCH;
            else if (!hv) rx_st <= RX_IDLE;
            else begin
                case (rx_st)
                    RX_WCH: begin
                        rx_st <= RX_WDAT;
                        wch   <= hn;
                        cnt   <= 4'd0;
                        acc   <= '0;
                    end
                    RX_WDAT: begin
                        acc   <= acc_n;
                        cnt   <= cnt + 4'd1;
                        rx_st <= cnt == WLAST ? RX_IDLE : RX_WDAT;
                    end
                    default: rx_st <= RX_IDLE;
                endcase
            end
        end
    end

    // a completed write lands with its strobe; channels beyond NCHAN match no slot and vanish
    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_IN <= '0;
            WR_STB  <= '0;
        end else begin
            for (int k = 0; k < NCHAN; k++) begin
                WR_STB[k] <= wr_fire && wch == 4'(k);
                if (wr_fire && wch == 4'(k)) DATA_IN[k*DW +: DW] <= acc_n;
            end
        end
    end

    // a channel differs from what the host last saw
    always_comb begin
        chg = '0;
        for (int k = 0; k < NCHAN; k++) chg[k] = DATA_OUT[k*DW +: DW] != shadow[k];
    end

`ifdef COMREGBRIDGE_ACK_EN
    logic [NCHAN-1:0] ack_pend;

    // acks owed for accepted writes; a new write wins over a same-cycle clear
    always_ff @(posedge CLK) begin
        if (RST) ack_pend <= '0;
        else begin
            for (int k = 0; k < NCHAN; k++) begin
                if (accept && sel_t == FR_ACK && sel_k == 4'(k)) ack_pend[k] <= 1'b0;
                if (wr_fire && wch == 4'(k)) ack_pend[k] <= 1'b1;
            end
        end
    end
`endif

    // pick the next frame: acks, then reads (lowest channel), then changes round-robin from rr
    always_comb begin
        hi_v = 1'b0;
        lo_v = 1'b0;
        hi_k = 4'd0;
        lo_k = 4'd0;
        for (int k = NCHAN - 1; k >= 0; k--) begin
            if (chg[k] && 4'(k) >= rr) begin
                hi_v = 1'b1;
                hi_k = 4'(k);
            end
            if (chg[k] && 4'(k) < rr) begin
                lo_v = 1'b1;
                lo_k = 4'(k);
            end
        end
        sel_t = FR_DATA;
        sel_v = |rd_pend || hi_v || lo_v;
        sel_k = hi_v ? hi_k : lo_k;
        for (int k = NCHAN - 1; k >= 0; k--) if (rd_pend[k]) sel_k = 4'(k);
`ifdef COMREGBRIDGE_ACK_EN
        if (|ack_pend) begin
            sel_t = FR_ACK;
            sel_v = 1'b1;
        end
        for (int k = NCHAN - 1; k >= 0; k--) if (ack_pend[k]) sel_k = 4'(k);
`endif
        sel_val = '0;
        for (int k = 0; k < NCHAN; k++) if (sel_k == 4'(k)) sel_val = DATA_OUT[k*DW +: DW];
    end

    // a sent data frame becomes the host's view of that channel and satisfies any pending read
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_pend <= '0;
            rr      <= 4'd0;
            for (int k = 0; k < NCHAN; k++) shadow[k] <= '0;
        end else begin
            for (int k = 0; k < NCHAN; k++) begin
                if (accept && sel_t == FR_DATA && sel_k == 4'(k)) begin
                    shadow[k]  <= sel_val;
                    rd_pend[k] <= 1'b0;
                    rr         <= k == NCHAN - 1 ? 4'd0 : 4'(k + 1);
                end
                if (rd_fire && hn == 4'(k)) rd_pend[k] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_com_regbridge.sv
// tb_com_regbridge: scoreboard bench for com_regbridge, a 4x8 instance on a monitored TX and a 16x16 instance
module tb_com_regbridge;

    localparam int CLK_FREQ = 12_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef COMREGBRIDGE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a = 1'b1, rst_b = 1'b1, rx_a = 1'b1, rx_b = 1'b1;
    logic         tx_a, tx_b;
    logic [31:0]  di_a;
    logic [31:0]  do_a = '0;
    logic [3:0]   stb_a;
    logic [255:0] di_b;
    logic [255:0] do_b = '0;
    logic [15:0]  stb_b;

    com_regbridge #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NCHAN(4), .DW(8)) dut_a (
        .CLK(clk), .RST(rst_a), .RX(rx_a), .TX(tx_a), .DATA_IN(di_a), .WR_STB(stb_a), .DATA_OUT(do_a)
    );

    com_regbridge #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NCHAN(16), .DW(16)) dut_b (
        .CLK(clk), .RST(rst_b), .RX(rx_b), .TX(tx_b), .DATA_IN(di_b), .WR_STB(stb_b), .DATA_OUT(do_b)
    );

    int n_chk = 0, n_fail = 0;
    int stb_cnt_a [4];
    int stb_b15 = 0, stb_b_other = 0;
    int cyc = 0, di_cyc = 0, stb_cyc = 0;
    logic [31:0] di_prev = '0;
    logic [7:0] expq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input bit sel_b, input logic [7:0] c);
        logic [9:0] f;
        f = {1'b1, c, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (sel_b) rx_b = f[i];
            else rx_a = f[i];
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic send_str(input bit sel_b, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(sel_b, s[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
    endtask

    task automatic expect_ack(input string s);
        if (ACK) expect_str(s);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (expq.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        repeat (DIV * 12) @(negedge clk);
        chk(tag, 64'(expq.size()), 64'd0);
    endtask

    // strobe counts and the cycles where DATA_IN moved / a strobe fired
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 4; k++) stb_cnt_a[k] += int'(stb_a[k]);
        stb_b15 += int'(stb_b[15]);
        stb_b_other += int'(|stb_b[14:0]);
        if (di_a != di_prev) di_cyc = cyc;
        if (|stb_a) stb_cyc = cyc;
        di_prev = di_a;
    end

    // TX decoder for instance A; every character is popped from the scoreboard
    initial begin
        logic [7:0] c;
        forever begin
            @(negedge tx_a);
            repeat (DIV / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(posedge clk);
                c[i] = tx_a;
            end
            repeat (DIV) @(posedge clk);
            chk("tx_stop_bit", 64'(tx_a), 64'd1);
            if (expq.size() == 0) chk("tx_unexpected", 64'(c), 64'h100);
            else chk("tx_char", 64'(c), 64'(expq.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_data_in_a", 64'(di_a), 64'd0);
        chk("rst_wr_stb_a", 64'(stb_a), 64'd0);
        chk("rst_tx_idle", 64'(tx_a), 64'd1);
        chk("rst_data_in_b", 64'(|di_b), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(negedge clk);

        send_str(0, "S2A5");
        expect_ack("K2\n");
        chk("wr_ch2", 64'(di_a), 64'h00A5_0000);
        chk("stb_ch2_once", 64'(stb_cnt_a[2]), 64'd1);
        chk("stb_others_quiet", 64'(stb_cnt_a[0] + stb_cnt_a[1] + stb_cnt_a[3]), 64'd0);
        chk("stb_aligned_ch2", 64'(stb_cyc), 64'(di_cyc));

        do_a[8 +: 8]  = 8'h3C;
        do_a[24 +: 8] = 8'hF0;
        expect_str("D13C\n");
        expect_str("D3F0\n");
        wait_drain("drain_rr0");
        do_a[8 +: 8] = 8'h11;
        expect_str("D111\n");
        wait_drain("drain_ch1");
        do_a[8 +: 8]  = 8'h3C;
        do_a[24 +: 8] = 8'h0F;
        expect_str("D30F\n");
        expect_str("D13C\n");
        wait_drain("drain_rr2");

        send_str(0, "R1");
        expect_str("D13C\n");
        wait_drain("drain_read");
        send_str(0, "R9");
        wait_drain("drain_bad_read");

        send_str(0, "S1G");
        send_str(0, "S0ff");
        expect_ack("K0\n");
        chk("wr_abort_ch1", 64'(di_a[15:8]), 64'd0);
        chk("wr_lower_ch0", 64'(di_a[7:0]), 64'hFF);
        chk("stb_aligned_ch0", 64'(stb_cyc), 64'(di_cyc));
        send_str(0, "S701");
        chk("wr_ch7_dropped", 64'(di_a), 64'h00A5_00FF);
        send_str(0, "S3BS3C1");
        expect_ack("K3\n");
        chk("wr_resync_ch3", 64'(di_a), 64'hC1A5_00FF);
        chk("stb_ch1_none", 64'(stb_cnt_a[1]), 64'd0);
        chk("stb_ch0_ch3", 64'(stb_cnt_a[0] * 10 + stb_cnt_a[3]), 64'd11);
        wait_drain("drain_writes");

        do_a[7:0] = 8'h12;
        expect_str("D012\n");
        repeat (20) @(negedge clk);
        do_a[16 +: 8] = 8'h77;
        repeat (10) @(negedge clk);
        do_a[16 +: 8] = 8'h00;
        repeat (DIV * 25) @(negedge clk);
        do_a[7:0] = 8'h34;
        expect_str("D034\n");
        wait_drain("drain_rereport");

        send_str(1, "SF1234");
        chk("b_ch15", 64'(di_b[240 +: 16]), 64'h1234);
        chk("b_others", 64'(|di_b[239:0]), 64'd0);
        chk("b_stb15", 64'(stb_b15), 64'd1);
        send_str(1, "SF12");
        chk("b_partial_hold", 64'(di_b[240 +: 16]), 64'h1234);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("b_rst_clear", 64'(|di_b), 64'd0);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        send_str(1, "34");
        repeat (4) @(negedge clk);
        chk("b_tail_ignored", 64'(|di_b), 64'd0);
        chk("b_stb15_total", 64'(stb_b15), 64'd1);
        chk("b_stb_other", 64'(stb_b_other), 64'd0);
        chk("b_tx_idle", 64'(tx_b), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
